// File: rtl/ram_dp_pipe.sv
// ram_dp_pipe: simple dual-port RAM with byte enables, a 1- or 2-stage read pipeline and a
// zero-fill sweep after reset. Define RAM_PARITY_EN to add per-byte even parity.
module ram_dp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int WR_FIRST   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_enb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
`ifdef RAM_PARITY_EN
  input  logic                    wr_par_flip,
  output logic                    rd_perr,
`endif
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   wr_new;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    wr_accept, rd_accept;
  logic [IW-1:0]           wr_idx, rd_idx, cnt_idx;

  logic                    a_valid;
  logic [DATA_WIDTH-1:0]   a_data;

`ifdef RAM_PARITY_EN
  logic [NB-1:0]           par_mem [DEPTH];
  logic [NB-1:0]           wr_par_new;
  logic                    rd_perr_now;
  logic                    a_perr;
  logic                    out_perr;

  function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction
`endif

  assign wr_idx    = wr_addr[IW-1:0];
  assign rd_idx    = rd_addr[IW-1:0];
  assign cnt_idx   = cnt_q[IW-1:0];
  assign wr_accept = (state_q == RUN) && wr_enb && (wr_addr <= LAST);
  assign rd_accept = (state_q == RUN) && rd_enb;
  assign init_done = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  // Merged write word is also what a write-first collision forwards to the read side.
  always_comb begin
    wr_new = mem[wr_idx];
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) wr_new[8*i +: 8] = wr_data[8*i +: 8];
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr <= LAST) begin
      rd_word = mem[rd_idx];
      if (WR_FIRST != 0 && wr_accept && wr_addr == rd_addr) rd_word = wr_new;
    end
  end

`ifdef RAM_PARITY_EN
  always_comb begin
    wr_par_new = par_mem[wr_idx];
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) wr_par_new[i] = ^wr_data[8*i +: 8];
    wr_par_new[0] = wr_par_new[0] ^ wr_par_flip;
  end

  always_comb begin
    rd_perr_now = 1'b0;
    if (rd_addr <= LAST) begin
      if (WR_FIRST != 0 && wr_accept && wr_addr == rd_addr)
        rd_perr_now = |(wr_par_new ^ lane_par(rd_word));
      else
        rd_perr_now = |(par_mem[rd_idx] ^ lane_par(rd_word));
    end
  end
`endif

  // Reset blocks writes; the sweep then owns the array until it reaches DEPTH-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem[cnt_idx] <= '0;
`ifdef RAM_PARITY_EN
        par_mem[cnt_idx] <= '0;
`endif
      end else if (wr_accept) begin
        mem[wr_idx] <= wr_new;
`ifdef RAM_PARITY_EN
        par_mem[wr_idx] <= wr_par_new;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else begin
      a_valid <= rd_accept;
      if (rd_accept) a_data <= rd_word;
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)            a_perr <= 1'b0;
    else if (rd_accept) a_perr <= rd_perr_now;
  end
`endif

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  b_valid;
      logic [DATA_WIDTH-1:0] b_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          b_valid <= 1'b0;
          b_data  <= '0;
        end else begin
          b_valid <= a_valid;
          if (a_valid) b_data <= a_data;
        end
      end
      assign rd_valid = b_valid;
      assign rd_data  = b_data;
`ifdef RAM_PARITY_EN
      logic b_perr;
      always_ff @(posedge clk) begin
        if (rst)          b_perr <= 1'b0;
        else if (a_valid) b_perr <= a_perr;
      end
      assign out_perr = b_perr;
`endif
    end else begin : g_lat1
      assign rd_valid = a_valid;
      assign rd_data  = a_data;
`ifdef RAM_PARITY_EN
      assign out_perr = a_perr;
`endif
    end
  endgenerate

`ifdef RAM_PARITY_EN
  assign rd_perr = rd_valid & out_perr;
`endif

endmodule
